// File: rtl/axi_wr_router_nto1_if.sv
// Bundle of every master-side and slave-side bus signal of the N:1 AXI3
// write router. The "slave" modport is the router's own view; the "master"
// modport is the surrounding fabric that drives it (the N masters plus the
// downstream slave port).
interface axi_wr_router_nto1_if #(
  parameter int NUM_M  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int SEL_W = $clog2(NUM_M);
  localparam int SID_W = ID_W + SEL_W;
  localparam int CTL_W = 18;
  localparam int AWP   = ADDR_W + ID_W + CTL_W;
  localparam int WP    = DATA_W + DATA_W/8 + 1;
  localparam int BP    = ID_W + 2;

  // master-facing side
  logic [NUM_M*AWP-1:0]            aw_m;
  logic [NUM_M-1:0]                awvalid_m;
  logic [NUM_M-1:0]                awready_m;
  logic [NUM_M*WP-1:0]             w_m;
  logic [NUM_M-1:0]                wvalid_m;
  logic [NUM_M-1:0]                wready_m;
  logic [NUM_M*BP-1:0]             b_m;
  logic [NUM_M-1:0]                bvalid_m;
  logic [NUM_M-1:0]                bready_m;

  // slave-facing side
  logic [ADDR_W+SID_W+CTL_W-1:0]   aw_s;
  logic                            awvalid_s;
  logic                            awready_s;
  logic [SID_W+WP-1:0]             w_s;
  logic                            wvalid_s;
  logic                            wready_s;
  logic [SID_W+1:0]                b_s;
  logic                            bvalid_s;
  logic                            bready_s;

  modport slave (
    input  aw_m, awvalid_m, w_m, wvalid_m, bready_m,
    output awready_m, wready_m, b_m, bvalid_m,
    output aw_s, awvalid_s, w_s, wvalid_s, bready_s,
    input  awready_s, wready_s, b_s, bvalid_s
  );

  modport master (
    output aw_m, awvalid_m, w_m, wvalid_m, bready_m,
    input  awready_m, wready_m, b_m, bvalid_m,
    input  aw_s, awvalid_s, w_s, wvalid_s, bready_s,
    output awready_s, wready_s, b_s, bvalid_s
  );
endinterface

// File: rtl/axi_wr_router_nto1.sv
// N-master to 1-slave AXI3 write-path router.
// AW: round-robin arbitration, master index prepended to the ID, one
// registered AW held until the slave accepts it.
// W : steered from the master at the head of a write-order queue, so data
// beats follow AW grant order; one queue entry per accepted AW.
// B : demultiplexed on the master-index bits of the returned ID.
module axi_wr_router_nto1 #(
  parameter int NUM_M    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int WQ_DEPTH = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  axi_wr_router_nto1_if.slave  bus
);
  localparam int SEL_W  = $clog2(NUM_M);
  localparam int SID_W  = ID_W + SEL_W;
  localparam int CTL_W  = 18;
  localparam int AWP    = ADDR_W + ID_W + CTL_W;
  localparam int WP     = DATA_W + DATA_W/8 + 1;
  localparam int BP     = ID_W + 2;
  localparam int AWS_W  = ADDR_W + SID_W + CTL_W;
  localparam int QA_W   = $clog2(WQ_DEPTH);
  localparam logic [QA_W:0] QCNT_FULL = (QA_W+1)'(WQ_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_rr, w_rr_nxt;
  logic [SEL_W-1:0]     w_hi, w_lo, w_gnt;
  logic                 w_hi_vld, w_lo_vld, w_gnt_vld;
  logic [AWP-1:0]       w_aw_sel;
  logic [AWS_W-1:0]     r_aw_s;
  logic [NUM_M-1:0]     w_awready_m;

  logic                 w_push, w_pop, w_full, w_empty;
  logic [QA_W-1:0]      r_wr, r_rd;
  logic [QA_W:0]        r_cnt;
  logic [SID_W-1:0]     r_q [WQ_DEPTH];
  logic [SID_W-1:0]     w_head;
  logic [SEL_W-1:0]     w_h;
  logic [WP-1:0]        w_wsel;
  logic                 w_wvalid_h, w_wvalid_s;
  logic [NUM_M-1:0]     w_wready_m;

  logic [SEL_W-1:0]     w_bsel;
  logic [NUM_M-1:0]     w_bvalid_m;
  logic [NUM_M*BP-1:0]  w_b_m;
  logic                 w_bready_s;

  assign w_full  = (r_cnt == QCNT_FULL);
  assign w_empty = (r_cnt == '0);

  // Round-robin pick: lowest requester at/above the pointer, else lowest overall
  always_comb begin
    w_hi     = '0;
    w_hi_vld = 1'b0;
    w_lo     = '0;
    w_lo_vld = 1'b0;
    for (int k = NUM_M-1; k >= 0; k--) begin
      if (bus.awvalid_m[k]) begin
        w_lo     = SEL_W'(k);
        w_lo_vld = 1'b1;
        if (SEL_W'(k) >= r_rr) begin
          w_hi     = SEL_W'(k);
          w_hi_vld = 1'b1;
        end
      end
    end
    w_gnt     = w_hi_vld ? w_hi : w_lo;
    w_gnt_vld = w_lo_vld;
    w_aw_sel  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_gnt == SEL_W'(k)) w_aw_sel = bus.aw_m[k*AWP +: AWP];
    end
  end

  // AW FSM next state: grant and push in IDLE, wait for slave accept in HOLD
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_push      = 1'b0;
    w_awready_m = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld && !w_full) begin
          w_push             = 1'b1;
          w_awready_m[w_gnt] = areset;
          w_rr_nxt           = (w_gnt == SEL_W'(NUM_M-1)) ? '0 : w_gnt + 1'b1;
          w_state_nxt        = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.awready_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // AW FSM state, rr pointer and the registered slave AW
  always_ff @(posedge aclk) begin
    if (!areset) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_aw_s  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      if (w_push)
        r_aw_s <= {w_aw_sel[AWP-1 -: ADDR_W], w_gnt,
                   w_aw_sel[CTL_W +: ID_W], w_aw_sel[CTL_W-1:0]};
    end
  end

  // Write-order queue pointers and occupancy; push is refused when full
  always_ff @(posedge aclk) begin
    if (!areset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Queue storage: {master index, master ID} of each granted AW
  always_ff @(posedge aclk) begin
    if (w_push) r_q[r_wr] <= {w_gnt, w_aw_sel[CTL_W +: ID_W]};
  end

  // W steering from the master at the queue head
  always_comb begin
    w_head     = r_q[r_rd];
    w_h        = w_head[SID_W-1:ID_W];
    w_wsel     = '0;
    w_wvalid_h = 1'b0;
    w_wready_m = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_h == SEL_W'(k)) begin
        w_wsel        = bus.w_m[k*WP +: WP];
        w_wvalid_h    = bus.wvalid_m[k];
        w_wready_m[k] = areset & ~w_empty & bus.wready_s;
      end
    end
    w_wvalid_s = areset & ~w_empty & w_wvalid_h;
    w_pop      = w_wvalid_s & bus.wready_s & w_wsel[0];
  end

  // B demux on the master-index bits; unknown index is sunk
  always_comb begin
    w_bsel     = bus.b_s[SID_W+1:ID_W+2];
    w_bvalid_m = '0;
    w_b_m      = '0;
    w_bready_s = areset;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_bsel == SEL_W'(k)) begin
        w_bvalid_m[k]       = areset & bus.bvalid_s;
        w_b_m[k*BP +: BP]   = bus.b_s[ID_W+1:0];
        w_bready_s          = areset & bus.bready_m[k];
      end
    end
  end

  assign bus.awready_m = w_awready_m;
  assign bus.aw_s      = r_aw_s;
  assign bus.awvalid_s = (r_state == S_HOLD);
  assign bus.w_s       = {w_head, w_wsel};
  assign bus.wvalid_s  = w_wvalid_s;
  assign bus.wready_m  = w_wready_m;
  assign bus.b_m       = w_b_m;
  assign bus.bvalid_m  = w_bvalid_m;
  assign bus.bready_s  = w_bready_s;

endmodule

// File: tb/tb_axi_wr_router_nto1.sv
// Directed bench for the N:1 AXI3 write router (4 masters, depth-4 queue).
module tb_axi_wr_router_nto1;
  localparam int NUM_M = 4, ADDR_W = 32, DATA_W = 32, ID_W = 4, WQ_DEPTH = 4;
  localparam int AWP = ADDR_W + ID_W + 18;
  localparam int WP  = DATA_W + DATA_W/8 + 1;

  logic aclk;
  logic areset;
  int   n_chk  = 0;
  int   n_pass = 0;

  axi_wr_router_nto1_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus();

  axi_wr_router_nto1 #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                       .WQ_DEPTH(WQ_DEPTH)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0]  b_s;
    logic        bvalid_s;
    logic [3:0]  bready_m;
    logic [3:0]  exp_bvalid_m;
    logic        exp_bready_s;
    logic [23:0] exp_b_m;
  } bvec_t;

  bvec_t tbl [5];
  logic [3:0] exp_ar [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [17:0] mk_ctl(input logic [3:0] len);
    return {2'b01, len, 3'b010, 2'b00, 4'b0000, 3'b000};
  endfunction

  task automatic set_aw(input int k, input logic [31:0] a, input logic [3:0] id, input logic [3:0] len);
    bus.aw_m[k*AWP +: AWP] = {a, id, mk_ctl(len)};
  endtask

  task automatic set_w(input int k, input logic [31:0] d, input logic [3:0] s, input logic l);
    bus.w_m[k*WP +: WP] = {d, s, l};
  endtask

  task automatic clr_inputs();
    bus.aw_m = '0; bus.awvalid_m = '0; bus.w_m = '0; bus.wvalid_m = '0;
    bus.bready_m = '0; bus.awready_s = 1'b0; bus.wready_s = 1'b0;
    bus.b_s = '0; bus.bvalid_s = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    areset = 1'b0;
    step();
    areset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h4C, 1'b1, 4'b0010, 4'b0010, 1'b1, 24'h000300};
    tbl[1] = '{8'hEA, 1'b1, 4'b0000, 4'b1000, 1'b0, 24'hA80000};
    tbl[2] = '{8'h15, 1'b0, 4'b0001, 4'b0000, 1'b1, 24'h000015};
    tbl[3] = '{8'hBF, 1'b1, 4'b1011, 4'b0100, 1'b0, 24'h03F000};
    tbl[4] = '{8'hBF, 1'b1, 4'b0100, 4'b0100, 1'b1, 24'h03F000};

    // ---------------- reset state, outputs gated while areset low
    clr_inputs();
    areset = 1'b0;
    step();
    bus.awvalid_m = 4'b1111; bus.wvalid_m = 4'b1111; bus.wready_s = 1'b1;
    bus.awready_s = 1'b1; bus.bvalid_s = 1'b1; bus.bready_m = 4'b1111; bus.b_s = 8'h4C;
    @(negedge aclk);
    chk("rst_awvalid_s", 64'(bus.awvalid_s), 64'h0);
    chk("rst_aw_s",      64'(bus.aw_s),      64'h0);
    chk("rst_awready_m", 64'(bus.awready_m), 64'h0);
    chk("rst_wvalid_s",  64'(bus.wvalid_s),  64'h0);
    chk("rst_wready_m",  64'(bus.wready_m),  64'h0);
    chk("rst_bvalid_m",  64'(bus.bvalid_m),  64'h0);
    chk("rst_bready_s",  64'(bus.bready_s),  64'h0);
    step();
    clr_inputs();
    areset = 1'b1;

    // ---------------- B demux table
    for (int i = 0; i < 5; i++) begin
      bus.b_s = tbl[i].b_s; bus.bvalid_s = tbl[i].bvalid_s; bus.bready_m = tbl[i].bready_m;
      @(negedge aclk);
      chk($sformatf("b_tbl%0d_bvalid_m", i), 64'(bus.bvalid_m), 64'(tbl[i].exp_bvalid_m));
      chk($sformatf("b_tbl%0d_bready_s", i), 64'(bus.bready_s), 64'(tbl[i].exp_bready_s));
      chk($sformatf("b_tbl%0d_b_m", i),      64'(bus.b_m),      64'(tbl[i].exp_b_m));
      step();
    end
    clr_inputs();

    // ---------------- single write from master 1
    do_reset();
    bus.awvalid_m = 4'b0010; set_aw(1, 32'h0000_1000, 4'h3, 4'd1); bus.awready_s = 1'b1;
    @(negedge aclk);
    chk("sw_awready_m", 64'(bus.awready_m), 64'h2);
    chk("sw_awvalid_pre", 64'(bus.awvalid_s), 64'h0);
    step();
    bus.awvalid_m = 4'b0000;
    bus.wvalid_m = 4'b0010; set_w(1, 32'hA0A0_0001, 4'hF, 1'b0); bus.wready_s = 1'b1;
    @(negedge aclk);
    chk("sw_awvalid_s", 64'(bus.awvalid_s), 64'h1);
    chk("sw_aw_s", 64'(bus.aw_s), 64'({32'h0000_1000, 2'd1, 4'h3, mk_ctl(4'd1)}));
    chk("sw_wvalid_s_b1", 64'(bus.wvalid_s), 64'h1);
    chk("sw_wready_m_b1", 64'(bus.wready_m), 64'h2);
    chk("sw_w_s_b1", 64'(bus.w_s), 64'({6'h13, 32'hA0A0_0001, 4'hF, 1'b0}));
    step();
    set_w(1, 32'hA0A0_0002, 4'h3, 1'b1);
    @(negedge aclk);
    chk("sw_awvalid_done", 64'(bus.awvalid_s), 64'h0);
    chk("sw_w_s_b2", 64'(bus.w_s), 64'({6'h13, 32'hA0A0_0002, 4'h3, 1'b1}));
    chk("sw_wready_m_b2", 64'(bus.wready_m), 64'h2);
    step();
    bus.b_s = 8'h4C; bus.bvalid_s = 1'b1; bus.bready_m = 4'b0010;
    @(negedge aclk);
    chk("sw_wvalid_s_empty", 64'(bus.wvalid_s), 64'h0);
    chk("sw_wready_m_empty", 64'(bus.wready_m), 64'h0);
    chk("sw_bvalid_m", 64'(bus.bvalid_m), 64'h2);
    chk("sw_b_m", 64'(bus.b_m), 64'h300);
    step();

    // ---------------- fairness: grants 0,1,2,3,0 two cycles apart
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_aw(k, 32'(k) << 8, 4'(k), 4'd0);
      set_w(k, 32'hF000_0000 + 32'(k), 4'hF, 1'b1);
    end
    bus.awvalid_m = 4'b1111; bus.wvalid_m = 4'b1111; bus.wready_s = 1'b1; bus.awready_s = 1'b1;
    exp_ar = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    for (int c = 0; c < 9; c++) begin
      @(negedge aclk);
      chk($sformatf("rr_c%0d_awready_m", c), 64'(bus.awready_m), 64'(exp_ar[c]));
      step();
    end

    // ---------------- queue full: 5th AW waits for a wlast handshake
    do_reset();
    for (int k = 0; k < 4; k++) set_aw(k, 32'h0000_8000 + 32'(k), 4'(k), 4'd0);
    set_w(0, 32'hC0C0_C0C0, 4'hF, 1'b1);
    bus.awvalid_m = 4'b1111; bus.awready_s = 1'b1; bus.wready_s = 1'b1;
    exp_ar = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk($sformatf("qf_c%0d_awready_m", c), 64'(bus.awready_m), 64'(exp_ar[c]));
      step();
    end
    bus.wvalid_m = 4'b0001;
    @(negedge aclk);
    chk("qf_pop_wready_m", 64'(bus.wready_m), 64'h1);
    chk("qf_pop_wvalid_s", 64'(bus.wvalid_s), 64'h1);
    chk("qf_pop_awready_m", 64'(bus.awready_m), 64'h0);
    step();
    bus.wvalid_m = 4'b0000;
    @(negedge aclk);
    chk("qf_after_awready_m", 64'(bus.awready_m), 64'h1);
    step();

    // ---------------- ordering: master 2 then master 0; master 0 W waits
    do_reset();
    set_aw(2, 32'h0000_3000, 4'h1, 4'd0);
    set_aw(0, 32'h0000_4000, 4'h5, 4'd0);
    bus.awvalid_m = 4'b0100; bus.awready_s = 1'b1; bus.wready_s = 1'b1;
    @(negedge aclk);
    chk("ord_gnt2", 64'(bus.awready_m), 64'h4);
    step();
    bus.awvalid_m = 4'b0001; bus.wvalid_m = 4'b0001; set_w(0, 32'hD000_0000, 4'hF, 1'b1);
    @(negedge aclk);
    chk("ord_early_wready_m", 64'(bus.wready_m), 64'h4);
    chk("ord_early_wvalid_s", 64'(bus.wvalid_s), 64'h0);
    step();
    @(negedge aclk);
    chk("ord_gnt0", 64'(bus.awready_m), 64'h1);
    chk("ord_wait_wready_m", 64'(bus.wready_m), 64'h4);
    step();
    bus.awvalid_m = 4'b0000; bus.wvalid_m = 4'b0101; set_w(2, 32'hD222_2222, 4'hF, 1'b1);
    @(negedge aclk);
    chk("ord_m2_wvalid_s", 64'(bus.wvalid_s), 64'h1);
    chk("ord_m2_wready_m", 64'(bus.wready_m), 64'h4);
    chk("ord_m2_w_s", 64'(bus.w_s), 64'({6'h21, 32'hD222_2222, 4'hF, 1'b1}));
    step();
    bus.wvalid_m = 4'b0001;
    @(negedge aclk);
    chk("ord_m0_wready_m", 64'(bus.wready_m), 64'h1);
    chk("ord_m0_wvalid_s", 64'(bus.wvalid_s), 64'h1);
    chk("ord_m0_w_s", 64'(bus.w_s), 64'({6'h05, 32'hD000_0000, 4'hF, 1'b1}));
    step();

    // ---------------- backpressure: awready_s low for 5 cycles
    do_reset();
    set_aw(0, 32'h0000_2000, 4'h7, 4'd0);
    set_aw(1, 32'h0000_5000, 4'h2, 4'd0);
    bus.awvalid_m = 4'b0001; bus.awready_s = 1'b0;
    @(negedge aclk);
    chk("bp_gnt0", 64'(bus.awready_m), 64'h1);
    step();
    bus.awvalid_m = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk($sformatf("bp_c%0d_awvalid_s", c), 64'(bus.awvalid_s), 64'h1);
      chk($sformatf("bp_c%0d_aw_s", c), 64'(bus.aw_s), 64'({32'h0000_2000, 2'd0, 4'h7, mk_ctl(4'd0)}));
      chk($sformatf("bp_c%0d_awready_m", c), 64'(bus.awready_m), 64'h0);
      step();
    end
    bus.awready_s = 1'b1;
    @(negedge aclk);
    chk("bp_accept_awvalid_s", 64'(bus.awvalid_s), 64'h1);
    chk("bp_accept_awready_m", 64'(bus.awready_m), 64'h0);
    step();
    @(negedge aclk);
    chk("bp_resume_awready_m", 64'(bus.awready_m), 64'h2);
    chk("bp_resume_awvalid_s", 64'(bus.awvalid_s), 64'h0);
    step();

    // ---------------- reset during beat 2 of a 4-beat burst
    do_reset();
    set_aw(1, 32'h0000_6000, 4'h9, 4'd3);
    bus.awvalid_m = 4'b0010; bus.awready_s = 1'b0;
    @(negedge aclk);
    chk("mr_gnt1", 64'(bus.awready_m), 64'h2);
    step();
    bus.awvalid_m = 4'b0000; bus.wvalid_m = 4'b0010; bus.wready_s = 1'b1;
    set_w(1, 32'hB000_0001, 4'hF, 1'b0);
    @(negedge aclk);
    chk("mr_beat1_wvalid_s", 64'(bus.wvalid_s), 64'h1);
    step();
    set_w(1, 32'hB000_0002, 4'hF, 1'b0);
    areset = 1'b0;
    @(negedge aclk);
    chk("mr_inrst_wvalid_s", 64'(bus.wvalid_s), 64'h0);
    chk("mr_inrst_wready_m", 64'(bus.wready_m), 64'h0);
    step();
    areset = 1'b1;
    bus.awready_s = 1'b1; bus.awvalid_m = 4'b1001;
    set_aw(0, 32'h0000_7000, 4'h4, 4'd0);
    set_aw(3, 32'h0000_7300, 4'h6, 4'd0);
    @(negedge aclk);
    chk("mr_after_awvalid_s", 64'(bus.awvalid_s), 64'h0);
    chk("mr_after_wvalid_s", 64'(bus.wvalid_s), 64'h0);
    chk("mr_after_wready_m", 64'(bus.wready_m), 64'h0);
    chk("mr_after_gnt0", 64'(bus.awready_m), 64'h1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_wr_router_nto1.md
Name: axi_wr_router_nto1

Overview:
- Parametrised N-master-to-1-slave AXI3 write-path router: AW arbitration, W steering, B demux.
- Successor to the fixed two-master write mux/demux pair; NUM_M=2 covers that case.
- Adds round-robin fairness, master-index ID extension for B routing, and a write-order queue so W beats follow AW grant order.
- Sits between master ports and one slave port of the interconnect.

Parameters:
- NUM_M, 4: number of masters (>=2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- ID_W, 4: master-side ID width.
- WQ_DEPTH, 4: write-order queue entries (power of 2).
- Derived: SEL_W=clog2(NUM_M); SID_W=ID_W+SEL_W; CTL_W=18 packs {burst[1:0],len[3:0],size[2:0],lock[1:0],cache[3:0],prot[2:0]}.
- Derived: AWP=ADDR_W+ID_W+CTL_W; WP=DATA_W+DATA_W/8+1; BP=ID_W+2.

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-low reset
aw_m  in  NUM_M*AWP  per master {awaddr,awid,ctl}; master k in slice k
awvalid_m  in  NUM_M  AW valid per master
awready_m  out  NUM_M  AW ready per master
w_m  in  NUM_M*WP  per master {wdata,wstrb,wlast}
wvalid_m  in  NUM_M  W valid per master
wready_m  out  NUM_M  W ready per master
b_m  out  NUM_M*BP  per master {bid,bresp}
bvalid_m  out  NUM_M  B valid per master
bready_m  in  NUM_M  B ready per master
aw_s  out  ADDR_W+SID_W+CTL_W  {awaddr,awid_s,ctl}
awvalid_s  out  1  slave AW valid
awready_s  in  1  slave AW ready
w_s  out  SID_W+WP  {wid_s,wdata,wstrb,wlast}
wvalid_s  out  1  slave W valid
wready_s  in  1  slave W ready
b_s  in  SID_W+2  {bid_s,bresp}
bvalid_s  in  1  slave B valid
bready_s  out  1  slave B ready

Behaviour:
- Reset: areset sampled low at an aclk edge clears everything.
  - Registered state after reset: awvalid_s=0, aw_s=0, awready_m=0, queue empty, rr pointer=0 (master 0 highest priority), FSM=IDLE.
  - Combinational outputs while areset=0: wvalid_s=0, wready_m=0, bvalid_m=0, bready_s=0.
  - Reset mid-operation discards all in-flight state; no completion is generated.
- AW FSM, IDLE:
  - If any awvalid_m and queue not full: select first requester at or after rr pointer (wrap NUM_M-1 -> 0).
  - In the same cycle, pulse awready_m[g]=1 for one cycle.
  - Register aw_s with awid_s={g[SEL_W-1:0],awid}.
  - Push {g,awid} into the queue; set rr pointer=g+1 mod NUM_M; go HOLD.
  - If the queue is full: awready_m=0 and stay IDLE.
- AW FSM, HOLD:
  - awvalid_s=1; aw_s held stable.
  - All awready_m=0.
  - On awready_s=1 go IDLE next cycle.
  - Latency: awvalid_m to awvalid_s is 1 cycle; maximum throughput is 1 AW per 2 cycles.
- W path, combinational from queue head h:
  - wvalid_s = ~empty & wvalid_m[h].
  - wready_m[h] = ~empty & wready_s; all other wready_m = 0.
  - w_s = {head ID, w_m[h]}.
  - W from a master is never forwarded before its AW is accepted by this block; it may precede awvalid_s (legal in AXI3).
- Queue:
  - Pop on wvalid_s & wready_s & wlast.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Pop on empty is impossible.
  - Push is blocked when full, even if a pop occurs that cycle.
  - Pointers wrap modulo WQ_DEPTH.
- B path, combinational:
  - s = bid_s[SID_W-1:ID_W].
  - bvalid_m[s]=bvalid_s; bready_s=bready_m[s]; b_m[s]={bid_s[ID_W-1:0],bresp}.
  - Other bvalid_m=0; other b_m slices=0.
  - s >= NUM_M: bready_s=1 (response dropped) and no bvalid_m asserted.

Test Plan:
- Single write: master 1, awid=3, addr=0x1000, len=1. After 1 cycle awvalid_s=1 with awid_s=0x13; 2 W beats pass with wid_s=0x13; B bid_s=0x13, bresp=0 -> bvalid_m[1]=1, bid=3, other bvalid_m=0.
- Fairness: all 4 awvalid_m held high after reset, awready_s=1 -> grant order 0,1,2,3,0; each awready_m pulse 2 cycles apart.
- Queue full: WQ_DEPTH=4, all wvalid_m=0. Four AWs accepted; the 5th awready_m stays 0. The cycle after a wlast handshake, awready_m pulses for the 5th.
- Ordering: master 2 granted before master 0; master 0 asserts wvalid early -> wready_m[0]=0 until master 2's wlast handshake completes, then master 0 data flows.
- Backpressure: awready_s=0 for 5 cycles -> awvalid_s=1 and aw_s unchanged; no awready_m pulse; grant resumes 1 cycle after awready_s rises.
- Reset mid-burst: areset=0 for 1 cycle during beat 2 of 4. Next cycle: awvalid_s=0, wvalid_s=0, wready_m=0, queue empty, next grant goes to master 0.
